// File: rtl/vedic_dot_accum.sv
// Dot-product accumulator fed by the 8x8 Vedic multiplier; sums N_TERMS products.
// Optional saturation on overflow: define VEDIC_DOT_SAT_EN.
module vedic_dot_accum #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    input  logic             flush,
    output logic [ACC_W-1:0] dot,
    output logic             dot_valid,
    output logic             dot_ovf,
    output logic [7:0]       term_idx,
    output logic             busy
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dot_d;
    logic [7:0]       idx_q, idx_d;
    logic             sticky_q, sticky_d;
    logic             dot_valid_d, dot_ovf_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_w;
    logic             carry;
    logic             last;

    // acc is zero in IDLE, so the first term shares the same adder
    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
        carry = sum[ACC_W];
`ifdef VEDIC_DOT_SAT_EN
        sum_w = carry ? '1 : sum[ACC_W-1:0];
`else
        sum_w = sum[ACC_W-1:0];
`endif
        last  = (state_q == ACCUM) && (idx_q == LAST);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sticky_d    = sticky_q;
        dot_d       = dot;
        dot_valid_d = 1'b0;
        dot_ovf_d   = dot_ovf;
        if (flush) begin
            state_d  = IDLE;
            acc_d    = '0;
            idx_d    = '0;
            sticky_d = 1'b0;
        end else if (prod_valid) begin
            if (last) begin
                dot_d       = sum_w;
                dot_valid_d = 1'b1;
                dot_ovf_d   = sticky_q | carry;
                state_d     = IDLE;
                acc_d       = '0;
                idx_d       = '0;
                sticky_d    = 1'b0;
            end else begin
                state_d  = ACCUM;
                acc_d    = sum_w;
                idx_d    = idx_q + 8'd1;
                sticky_d = sticky_q | carry;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            sticky_q  <= 1'b0;
            dot       <= '0;
            dot_valid <= 1'b0;
            dot_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            sticky_q  <= sticky_d;
            dot       <= dot_d;
            dot_valid <= dot_valid_d;
            dot_ovf   <= dot_ovf_d;
        end
    end

    assign term_idx = idx_q;
    assign busy     = (state_q == ACCUM);

endmodule

// File: doc/vedic_dot_accum.md
# vedic_dot_accum

Dot-product accumulation stage that sits directly downstream of the 8x8 Vedic multiplier in the matrix-multiply datapath. It consumes one 16-bit unsigned product per `done` pulse from the multiplier and sums exactly `N_TERMS` products into one dot-product element. It presents that element with a one-cycle valid pulse and an overflow flag. Back-to-back dot products stream without idle cycles.

## Interface
- `N_TERMS`, default 8: products summed per dot-product element; legal range 2..255.
- `ACC_W`, default 19: accumulator/output width; legal range 16..32. The full-precision width is 16 + clog2(N_TERMS).
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `prod` input, 16 bits: unsigned product; connect to the multiplier `result`.
- `prod_valid` input, 1 bit: single-cycle qualifier for `prod`; connect to the multiplier `done`.
- `flush` input, 1 bit: synchronous abort; discards the partial sum.
- `dot` output, ACC_W bits: completed dot-product element; held until the next completion.
- `dot_valid` output, 1 bit: one-cycle pulse marking a new `dot`.
- `dot_ovf` output, 1 bit: overflow status of the element in `dot`; updates with `dot_valid`.
- `term_idx` output, 8 bits: number of products accumulated so far in the current element.
- `busy` output, 1 bit: high while a partial sum is held (state ACCUM).

## Operation
- Two-state FSM:
  - IDLE: `acc` = 0, `term_idx` = 0.
  - ACCUM: 0 < `term_idx` < N_TERMS.
- IDLE with `prod_valid` and N_TERMS > 1: `acc` <= zero-extended `prod`; `term_idx` <= 1; state -> ACCUM.
- ACCUM with `prod_valid` when `term_idx` < N_TERMS-1: `acc` <= `acc` + `prod`; `term_idx` increments.
- ACCUM with `prod_valid` when `term_idx` = N_TERMS-1 (last term):
  - `dot` <= `acc` + `prod`.
  - `dot_valid` <= 1 and `dot_ovf` <= sticky overflow.
  - `acc`, `term_idx` and the sticky flag clear; state -> IDLE.
- Without `prod_valid`, all state holds; gaps between products are allowed.
- Arithmetic:
  - Sum is computed at ACC_W+1 bits.
  - Overflow is carry-out of bit ACC_W-1 on any add; the sticky flag ORs this across the element.
  - The result stored is bits [ACC_W-1:0] (modulo 2^ACC_W).
  - With ACC_W >= 16 + clog2(N_TERMS), overflow is impossible.
- `flush`:
  - Highest priority: state -> IDLE; `acc`, `term_idx` and the sticky flag clear.
  - A `prod_valid` in the same cycle is discarded.
  - `dot`, `dot_ovf` and `dot_valid` are unaffected; a pending pulse still occurs only if it was registered before the flush.
- The multiplier has no stall input, so there is no backpressure: every `prod_valid` not coinciding with `flush` is consumed.

## Timing
- Reset values: `dot` = 0, `dot_valid` = 0, `dot_ovf` = 0, `term_idx` = 0, `busy` = 0, state IDLE.
- Reset asserted mid-element: the partial sum is lost immediately, asynchronously.
- Latency: `dot_valid` is high in the cycle after the clock edge that sampled the last `prod_valid`. Registered outputs only; no combinational input-to-output path.
- `dot_valid` is high for exactly one cycle per element.
- Back-to-back streaming: `prod_valid` in the cycle immediately after the last term is accepted from IDLE as term 1 of the next element. Full throughput is one product per cycle.
- `busy` and `term_idx` reflect registered state, valid the cycle after each accepted product.

## Configuration
- `VEDIC_DOT_SAT_EN` defined:
  - On overflow, `acc` (and the final `dot`) clamps to 2^ACC_W − 1 and remains there for the rest of the element.
  - `dot_ovf` is set.
- `VEDIC_DOT_SAT_EN` undefined: sums wrap modulo 2^ACC_W; `dot_ovf` still reports overflow.

## Test plan
- Reset and single element (N_TERMS=4, ACC_W=18):
  - Check all outputs are 0 after reset.
  - Drive products 1, 2, 3, 4 with 0–3 idle cycles between them -> `dot`=10, `dot_valid` one cycle after the 4th product, `dot_ovf`=0.
- Back-to-back (N_TERMS=4, ACC_W=18):
  - Drive 8 consecutive-cycle products of 65025 -> two pulses 4 cycles apart, each `dot`=260100, `dot_ovf`=0.
  - `busy` must not drop between the elements except for the single IDLE-accept cycle.
- Overflow (N_TERMS=4, ACC_W=17), 4×65025:
  - Without the macro -> `dot`=129028, `dot_ovf`=1.
  - With `VEDIC_DOT_SAT_EN` -> `dot`=131071, `dot_ovf`=1.
- Flush (N_TERMS=4, ACC_W=18):
  - After 2 products of 100, assert `flush` together with a third product -> `term_idx`=0 and no pulse.
  - Then products 5, 6, 7, 8 -> `dot`=26.
- Asynchronous reset mid-element:
  - Assert `reset` between clock edges after 3 products -> `busy` and `term_idx` clear immediately.
  - Release, then products 1, 1, 1, 1 -> `dot`=4.
- End-to-end with the 8x8 multiplier, N_TERMS=8:
  - Feed a·b pairs (255,255)×8 -> `dot`=520200, `dot_ovf`=0.
